// File: rtl/traffic_lights_monitor.sv
// traffic_lights_monitor: segments the lamp stream, reports each segment's length in ms, flags bad patterns.
// Optional phase-order checking is compiled in with `define TL_MON_SEQ_CHECK_EN.
module traffic_lights_monitor #(
    parameter int CLK_PER_MS = 2,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             red_i,
    input  logic             yellow_i,
    input  logic             green_i,
    output logic             seg_valid_o,
    output logic [2:0]       seg_code_o,
    output logic [LEN_W-1:0] seg_len_o,
    output logic             pat_err_o,
    output logic             seq_err_o
);
    localparam int SUB_W = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
    localparam logic [2:0] OFF = 3'd0, RED = 3'd1, RY = 3'd2, YEL = 3'd3, GRN = 3'd4, UNK = 3'd5, ILL = 3'd7;
    logic [2:0]       pat_d, pat_q;
    logic [SUB_W-1:0] sub_d, sub_q, sub_base;
    logic [LEN_W-1:0] ms_d, ms_q, ms_base;
    logic             chg, rpt, wrap;
    logic             seg_valid_q, pat_err_q;
    logic [2:0]       seg_code_q;
    logic [LEN_W-1:0] seg_len_q;
    always_comb begin
        pat_d    = {red_i, yellow_i, green_i} == 3'b000 ? OFF :
                   {red_i, yellow_i, green_i} == 3'b100 ? RED :
                   {red_i, yellow_i, green_i} == 3'b110 ? RY  :
                   {red_i, yellow_i, green_i} == 3'b010 ? YEL :
                   {red_i, yellow_i, green_i} == 3'b001 ? GRN : ILL;
        chg      = pat_d != pat_q;
        rpt      = chg && pat_q != UNK;
        // a fresh pattern counts its first sampled cycle as cycle 1
        sub_base = chg ? '0 : sub_q;
        ms_base  = chg ? '0 : ms_q;
        wrap     = sub_base == SUB_W'(CLK_PER_MS - 1);
        sub_d    = wrap ? '0 : sub_base + 1'b1;
        ms_d     = (wrap && ms_base != '1) ? ms_base + 1'b1 : ms_base;
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pat_q       <= UNK;
            sub_q       <= '0;
            ms_q        <= '0;
            seg_valid_q <= 1'b0;
            seg_code_q  <= '0;
            seg_len_q   <= '0;
            pat_err_q   <= 1'b0;
        end else begin
            pat_q       <= pat_d;
            sub_q       <= sub_d;
            ms_q        <= ms_d;
            seg_valid_q <= rpt;
            seg_code_q  <= rpt ? pat_q : seg_code_q;
            seg_len_q   <= rpt ? ms_q : seg_len_q;
            pat_err_q   <= pat_err_q | (pat_d == ILL);
        end
    end
    assign seg_valid_o = seg_valid_q;
    assign seg_code_o  = seg_code_q;
    assign seg_len_o   = seg_len_q;
    assign pat_err_o   = pat_err_q;
`ifdef TL_MON_SEQ_CHECK_EN
    logic legal, seq_bad, seq_err_q;
    always_comb begin
        legal   = pat_d == OFF ||
                  (pat_q == OFF && (pat_d == GRN || pat_d == YEL || pat_d == RED)) ||
                  (pat_q == RED && pat_d == RY) || (pat_q == RY && pat_d == GRN) ||
                  (pat_q == GRN && pat_d == YEL) || (pat_q == YEL && pat_d == RED);
        // transitions touching ILLEGAL belong to pat_err_o only
        seq_bad = rpt && pat_q != ILL && pat_d != ILL && !legal;
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) seq_err_q <= 1'b0;
        else        seq_err_q <= seq_err_q | seq_bad;
    end
    assign seq_err_o = seq_err_q;
`else
    assign seq_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_lights_monitor.sv
// tb_traffic_lights_monitor: directed lamp vectors feed a queue of expected strobes checked by a monitor.
module tb_traffic_lights_monitor;
    logic       clk = 1'b0, srst = 1'b1, red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic       seg_valid, pat_err, seq_err;
    logic [2:0] seg_code;
    logic [7:0] seg_len;
    logic [10:0] exp_q[$];
    int checks = 0, passed = 0;
`ifdef TL_MON_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    traffic_lights_monitor #(.CLK_PER_MS(2), .LEN_W(8)) dut (
        .clk_i(clk), .srst_i(srst), .red_i(red), .yellow_i(yellow), .green_i(green),
        .seg_valid_o(seg_valid), .seg_code_o(seg_code), .seg_len_o(seg_len),
        .pat_err_o(pat_err), .seq_err_o(seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // drive a lamp pattern for n cycles; e/c/l describe the strobe this change should cause
    task automatic step(input logic [2:0] ryg, input int n, input logic e, input logic [2:0] c, input logic [7:0] l);
        {red, yellow, green} = ryg;
        if (e) exp_q.push_back({c, l});
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (seg_valid) begin
            if (exp_q.size() == 0) chk("unexpected_strobe", {seg_code, seg_len}, 0);
            else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("seg_code", seg_code, e[10:8]);
                chk("seg_len", seg_len, e[7:0]);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", seg_valid, 0);
        chk("rst_pat_err", pat_err, 0);
        srst = 1'b0;
        step(3'b100, 10, 0, 0, 0);
        step(3'b110, 6, 1, 1, 5);
        step(3'b001, 8, 1, 2, 3);
        step(3'b000, 4, 1, 4, 4);
        step(3'b001, 4, 1, 0, 2);
        step(3'b000, 4, 1, 4, 2);
        step(3'b001, 4, 1, 0, 2);
        step(3'b000, 4, 1, 4, 2);
        step(3'b010, 6, 1, 0, 2);
        step(3'b100, 4, 1, 3, 3);
        chk("legal_seq_err", seq_err, 0);
        chk("legal_pat_err", pat_err, 0);
        step(3'b101, 1, 1, 1, 2);
        chk("illegal_pat_err", pat_err, 1);
        step(3'b100, 6, 1, 7, 0);
        chk("pat_err_sticky", pat_err, 1);
        chk("seq_err_pre_bad", seq_err, 0);
        step(3'b001, 2, 1, 1, 3);
        chk("red_green_seq_err", seq_err, SEQ_EXP);
        step(3'b010, 7, 1, 4, 1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", seg_valid, 0);
        chk("mid_rst_code", seg_code, 0);
        chk("mid_rst_len", seg_len, 0);
        chk("mid_rst_pat_err", pat_err, 0);
        chk("mid_rst_seq_err", seq_err, 0);
        srst = 1'b0;
        step(3'b100, 600, 0, 0, 0);
        step(3'b110, 2, 1, 1, 8'hFF);
        step(3'b000, 3, 1, 2, 1);
        chk("final_seq_err", seq_err, 0);
        chk("final_pat_err", pat_err, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/traffic_lights_monitor.md
Name: traffic_lights_monitor

Overview:
- Passive observer on the lamp outputs (red/yellow/green) of the traffic light controller; the decode side of the lamp interface.
- Splits the lamp stream into segments of constant lamp pattern, measures each segment's duration in ms and reports it with a one-cycle valid strobe.
- Flags illegal lamp combinations and, optionally, illegal phase order.
- Used in system self-check and as a bench scoreboard front-end.

Parameters:
- CLK_PER_MS, 2, clock cycles per millisecond; integer >= 1.
- LEN_W, 16, width of the reported segment length in ms.

Ports:
- clk_i  input  1  system clock
- srst_i  input  1  synchronous reset, active-high
- red_i  input  1  red lamp, same clock domain, no synchronizer
- yellow_i  input  1  yellow lamp
- green_i  input  1  green lamp
- seg_valid_o  output  1  one-cycle strobe: a segment has completed
- seg_code_o  output  3  pattern code of the completed segment
- seg_len_o  output  LEN_W  completed segment length in whole ms
- pat_err_o  output  1  sticky: illegal lamp combination seen
- seq_err_o  output  1  sticky: illegal phase transition seen (0 when feature is off)

Behaviour:
- Reset: all outputs 0. Internal pattern register = UNKNOWN. Counters cleared. First-segment flag set.
- Pattern codes (combinational from r,y,g):
  - 000 -> OFF = 0
  - 100 -> RED = 1
  - 110 -> RED_YELLOW = 2
  - 010 -> YELLOW = 3
  - 001 -> GREEN = 4
  - any other combination -> ILLEGAL = 7
- UNKNOWN (internal only) = 5.
- Inputs are sampled every cycle. pat_q holds the pattern sampled in the previous cycle.
- Length counting:
  - sub_cnt counts cycles 0..CLK_PER_MS-1. On wrap, ms_cnt increments, saturating at all-ones.
  - A segment of N held cycles reports floor(N / CLK_PER_MS), saturated.
  - The cycle in which a new pattern is first sampled is cycle 1 of the new segment.
- Segment end: when the sampled pattern differs from pat_q and pat_q != UNKNOWN, the next cycle drives seg_valid_o=1, seg_code_o=pat_q, seg_len_o=length.
  - Outputs are registered; latency is 1 cycle after the first cycle of the new pattern.
  - seg_code_o and seg_len_o hold their values until the next strobe.
- First segment after reset: the UNKNOWN->X transition starts counting without a report. The segment that follows is reported with its partial length.
- Back-to-back changes on consecutive cycles: each produces a strobe. A 1-cycle segment reports len = 0 when CLK_PER_MS > 1.
- ILLEGAL pattern: pat_err_o is set in the cycle after it is first sampled and stays set until srst_i. Segments with code 7 are still reported.
- Reset mid-segment: counters and pat_q are cleared, no strobe is issued for the interrupted segment, and sticky errors clear.
- No backpressure: a consumer must accept a strobe in the cycle it is asserted.

Optional Feature:
- Macro: TL_MON_SEQ_CHECK_EN.
- Defined: each reported transition pat_q -> new pattern is checked against the legal set:
  - RED->RED_YELLOW, RED_YELLOW->GREEN
  - GREEN->OFF, OFF->GREEN (green blink)
  - GREEN->YELLOW, OFF->YELLOW
  - YELLOW->RED
  - YELLOW->OFF, OFF->YELLOW (unregulated blink)
  - RED->OFF, any->OFF (off mode)
  - OFF->RED
- Any other transition between two non-UNKNOWN, non-ILLEGAL patterns sets sticky seq_err_o in the strobe cycle.
- Transitions to or from ILLEGAL are covered by pat_err_o only. The first transition after reset is not checked.
- Not defined: seq_err_o is tied to 0 and no sequence logic is instantiated.

Test Plan:
- Reset, then red 10 cycles, red+yellow 6, green 8 (CLK_PER_MS=2) -> strobes (1,len partial), (2,3) after the red->RY change; green->next strobe (4,4); both error flags stay 0.
- Green/off alternation 4 cycles each, 3 times, then yellow 6, then red -> strobes (4,2),(0,2) repeated, then (3,3); seq_err_o=0 with TL_MON_SEQ_CHECK_EN defined.
- Red and green high together for 1 cycle -> pat_err_o=1 from the next cycle, strobe with code 7, len 0; flag stays high until srst_i.
- Red 6 cycles then green directly -> with TL_MON_SEQ_CHECK_EN, seq_err_o=1 in the strobe cycle; without it, seq_err_o remains 0.
- srst_i pulsed after 7 cycles of yellow -> no strobe for yellow, outputs 0; the next change reports no segment (first-segment rule).
- Red held 140000 cycles, then red+yellow -> strobe (1, 16'hFFFF) (saturation).
